// File: rtl/emissor_notas.sv
// Phrase emitter: on request plays a five-note phrase chosen by tipo, one note
// strobe per EMIT followed by GAP idle cycles, then a one-cycle end pulse.
module emissor_notas #(
  parameter int GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tipo,
  input  logic       tom_in,
  output logic       ok,
  output logic [2:0] nota,
  output logic       tom,
  output logic       busy,
  output logic       fim,
  output logic       erro,
  output logic [6:0] display
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_L = 4'(GAP);
  localparam logic [6:0] SEG0  = 7'b1111110;

  state_t     state_q;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [3:0] cnt_q;
  logic [1:0] tipo_q;
  logic       ok_q, tom_q, busy_q, fim_q, erro_q;
  logic [2:0] nota_q;
  logic [6:0] disp_q;

  function automatic logic [2:0] note_of(input logic [1:0] t, input logic [2:0] i);
    logic [2:0] n;
    n = 3'd0;
    unique case (t)
      2'b01: n = i;                          // do re mi fa sol
      2'b10: n = 3'd6 - i;                   // sol fa mi re do
      2'b11: case (i)                        // do mi sol si la
               3'd1: n = 3'd1;
               3'd2: n = 3'd3;
               3'd3: n = 3'd5;
               3'd4: n = 3'd7;
               3'd5: n = 3'd6;
               default: n = 3'd0;
             endcase
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [2:0] i);
    logic [6:0] s;
    case (i)
      3'd0: s = 7'b1111110;
      3'd1: s = 7'b0110000;
      3'd2: s = 7'b1101101;
      3'd3: s = 7'b1111001;
      3'd4: s = 7'b0110011;
      3'd5: s = 7'b1011011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign idx_d = idx_q + 3'd1;

  // Outputs are computed together with the state transition, so each is the
  // registered value belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      tipo_q  <= 2'b00;
      ok_q    <= 1'b0;
      nota_q  <= 3'd0;
      tom_q   <= 1'b0;
      busy_q  <= 1'b0;
      fim_q   <= 1'b0;
      erro_q  <= 1'b0;
      disp_q  <= SEG0;
    end else begin
      ok_q   <= 1'b0;
      fim_q  <= 1'b0;
      erro_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (tipo != 2'b00) begin
              state_q <= S_EMIT;
              tipo_q  <= tipo;
              tom_q   <= tom_in;
              idx_q   <= 3'd1;
              cnt_q   <= GAP_L;
              ok_q    <= 1'b1;
              nota_q  <= note_of(tipo, 3'd1);
              busy_q  <= 1'b1;
              disp_q  <= seg_of(3'd1);
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        S_EMIT: state_q <= S_GAP;
        S_GAP: begin
          if (cnt_q <= 4'd1) begin
            if (idx_q < 3'd5) begin
              state_q <= S_EMIT;
              idx_q   <= idx_d;
              cnt_q   <= GAP_L;
              ok_q    <= 1'b1;
              nota_q  <= note_of(tipo_q, idx_d);
              disp_q  <= seg_of(idx_d);
            end else begin
              state_q <= S_DONE;
              fim_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          idx_q   <= 3'd0;
          tipo_q  <= 2'b00;
          nota_q  <= 3'd0;
          tom_q   <= 1'b0;
          busy_q  <= 1'b0;
          disp_q  <= SEG0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ok      = ok_q;
  assign nota    = nota_q;
  assign tom     = tom_q;
  assign busy    = busy_q;
  assign fim     = fim_q;
  assign erro    = erro_q;
  assign display = disp_q;

endmodule

// File: tb/tb_emissor_notas.sv
// Directed bench for emissor_notas: GAP=2 instance for phrase/error/reset
// behaviour, GAP=1 instance for the shorter spacing.
module tb_emissor_notas;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, tom_in;
  logic [1:0] tipo;
  logic       ok, tom, busy, fim, erro;
  logic [2:0] nota;
  logic [6:0] display;

  logic       start2, tom_in2;
  logic [1:0] tipo2;
  logic       ok2, tom2, busy2, fim2, erro2;
  logic [2:0] nota2;
  logic [6:0] display2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [6] = '{7'b1111110, 7'b0110000, 7'b1101101,
                              7'b1111001, 7'b0110011, 7'b1011011};

  always #5 clk = ~clk;

  emissor_notas #(.GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .tipo(tipo), .tom_in(tom_in),
    .ok(ok), .nota(nota), .tom(tom), .busy(busy), .fim(fim), .erro(erro),
    .display(display)
  );

  emissor_notas #(.GAP(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tipo(tipo2), .tom_in(tom_in2),
    .ok(ok2), .nota(nota2), .tom(tom2), .busy(busy2), .fim(fim2), .erro(erro2),
    .display(display2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ok"},   8'(ok),      8'd0);
    chk({tag, "_nota"}, 8'(nota),    8'd0);
    chk({tag, "_tom"},  8'(tom),     8'd0);
    chk({tag, "_busy"}, 8'(busy),    8'd0);
    chk({tag, "_fim"},  8'(fim),     8'd0);
    chk({tag, "_erro"}, 8'(erro),    8'd0);
    chk({tag, "_disp"}, 8'(display), 8'h7E);
  endtask

  // tab packs the five expected notes, first note in the top bits.
  task automatic run_phrase(input string tag, input logic [1:0] ty, input logic tm,
                            input logic [14:0] tab);
    logic eo;
    tipo = ty; tom_in = tm; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      eo = (c % 3 == 1) && (c <= 13);
      chk({tag, "_ok"}, 8'(ok), 8'(eo));
      if (eo) begin
        chk({tag, "_nota"}, 8'(nota), 8'(tab[14 - 3*((c-1)/3) -: 3]));
        chk({tag, "_disp"}, 8'(display), 8'(seg_tab[(c-1)/3 + 1]));
      end
      chk({tag, "_tom"},  8'(tom),  8'((c <= 16) ? tm : 1'b0));
      chk({tag, "_fim"},  8'(fim),  8'(c == 16));
      chk({tag, "_busy"}, 8'(busy), 8'(c <= 16));
      if (c == 5) begin
        tipo = ~ty; tom_in = ~tm; start = 1'b1;
      end
      if (c == 15) begin
        tipo = ty; tom_in = tm; start = 1'b0;
      end
      step();
    end
    chk({tag, "_endnota"}, 8'(nota), 8'd0);
    chk({tag, "_enddisp"}, 8'(display), 8'h7E);
  endtask

  initial begin
    logic eo;
    int   p;
    reset = 1'b1; start = 1'b0; tipo = 2'b00; tom_in = 1'b0;
    start2 = 1'b0; tipo2 = 2'b00; tom_in2 = 1'b0;
    step(); step();
    chk_idle("rst");
    reset = 1'b0;
    step();
    chk_idle("rst_rel");

    // adj phrase with tom=1, spacing k+1,k+4,...; fim k+16; idle k+17
    run_phrase("adj", 2'b01, 1'b1, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
    // adv phrase with tom=0
    run_phrase("adv", 2'b11, 1'b0, {3'd1, 3'd3, 3'd5, 3'd7, 3'd6});

    // tipo=00 start: only an erro pulse
    tipo = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    chk("err_erro", 8'(erro), 8'd1);
    chk("err_ok",   8'(ok),   8'd0);
    chk("err_busy", 8'(busy), 8'd0);
    chk("err_fim",  8'(fim),  8'd0);
    step();
    chk_idle("err_after");

    // reset during the third note aborts the phrase
    tipo = 2'b01; tom_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    chk("ab_ok3",   8'(ok),   8'd1);
    chk("ab_nota3", 8'(nota), 8'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("ab_rst");
    for (int c = 0; c < 12; c++) begin
      chk("ab_nofim",  8'(fim),  8'd0);
      chk("ab_nobusy", 8'(busy), 8'd0);
      step();
    end
    run_phrase("replay", 2'b01, 1'b1, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});

    // reset wins over a simultaneous start
    tipo = 2'b10; start = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    chk_idle("rst_prio");

    // continuous start with comp: back-to-back phrases, one IDLE cycle apart
    tipo = 2'b10; start = 1'b1;
    step();
    for (int c = 1; c <= 34; c++) begin
      p  = (c - 1) % 17 + 1;
      eo = (p % 3 == 1) && (p <= 13);
      chk("cont_ok", 8'(ok), 8'(eo));
      if (eo) chk("cont_nota", 8'(nota), 8'(5 - (p - 1) / 3));
      chk("cont_fim",  8'(fim),  8'(p == 16));
      chk("cont_busy", 8'(busy), 8'(p <= 16));
      if (c == 6)  tipo = 2'b01;
      if (c == 10) tipo = 2'b10;
      if (c == 24) tipo = 2'b11;
      if (c == 30) tipo = 2'b10;
      if (c == 33) start = 1'b0;
      step();
    end
    chk("cont_stop", 8'(busy), 8'd0);

    // GAP=1 instance: ok at k+1,k+3,...,k+9; fim at k+11
    tipo2 = 2'b01; tom_in2 = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      eo = (c % 2 == 1) && (c <= 9);
      chk("g1_ok", 8'(ok2), 8'(eo));
      if (eo) chk("g1_nota", 8'(nota2), 8'((c + 1) / 2));
      chk("g1_fim",  8'(fim2),  8'(c == 11));
      chk("g1_busy", 8'(busy2), 8'(c <= 11));
      chk("g1_tom",  8'(tom2),  8'(c <= 11));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
